// File: rtl/aes_128_word_loader.sv
// Word-stream front end for the pipelined aes_128 core: assembles key/plaintext blocks from
// 32-bit words, issues them to the core under a credit limit, and tracks ciphertext validity.
module aes_128_word_loader #(
    parameter int CORE_LATENCY = 20,
    parameter int CREDITS      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_sel,
    input  logic         credit_ret,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    output logic         issue,
    output logic         out_valid,
    output logic         key_loaded,
    output logic         err_nokey
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    logic [CW-1:0]           credit_cnt;
    logic [CW-1:0]           credit_next;
    logic [1:0]              key_cnt;
    logic [1:0]              st_cnt;
    logic [127:0]            shadow_key;
    logic [127:0]            active_key;
    logic [127:0]            st_shift;
    logic [CORE_LATENCY-1:0] valid_line;
    logic                    key_xfer;
    logic                    st_xfer;
    logic                    st_done;
    logic                    issue_now;

    assign in_ready  = (credit_cnt != '0);
    assign key_xfer  = in_valid && in_ready && in_sel;
    assign st_xfer   = in_valid && in_ready && !in_sel;
    assign st_done   = st_xfer && (st_cnt == 2'd3);
    assign issue_now = st_done && key_loaded;
    assign out_valid = valid_line[CORE_LATENCY-1];

    // A simultaneous issue and returned credit cancel out; returns beyond the pool size are dropped.
    always_comb begin
        credit_next = credit_cnt;
        if (issue_now && !credit_ret) begin
            credit_next = credit_cnt - 1'b1;
        end else if (credit_ret && !issue_now && (credit_cnt != CREDIT_MAX)) begin
            credit_next = credit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_MAX;
            key_cnt    <= 2'd0;
            st_cnt     <= 2'd0;
            shadow_key <= '0;
            active_key <= '0;
            st_shift   <= '0;
            core_state <= '0;
            core_key   <= '0;
            valid_line <= '0;
            issue      <= 1'b0;
            key_loaded <= 1'b0;
            err_nokey  <= 1'b0;
        end else begin
            credit_cnt    <= credit_next;
            issue         <= issue_now;
            valid_line[0] <= issue;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                valid_line[i] <= valid_line[i-1];
            end

            if (key_xfer) begin
                shadow_key <= {shadow_key[95:0], in_data};
                key_cnt    <= key_cnt + 2'd1;
                if (key_cnt == 2'd3) begin
                    active_key <= {shadow_key[95:0], in_data};
                    key_loaded <= 1'b1;
                end
            end

            if (st_xfer) begin
                st_shift <= {st_shift[95:0], in_data};
                st_cnt   <= st_cnt + 2'd1;
            end

            // Core inputs only move on a real issue; otherwise they hold their last block.
            if (st_done) begin
                if (key_loaded) begin
                    core_state <= {st_shift[95:0], in_data};
                    core_key   <= active_key;
                end else begin
                    err_nokey  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_128_word_loader.sv
// Directed bench for aes_128_word_loader: checks block assembly, issue/out_valid timing,
// credit flow, missing-key handling and mid-stream reset on the loader's own outputs.
module tb_aes_128_word_loader;
    localparam int L  = 20;
    localparam int CR = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_sel = 1'b0;
    logic         credit_ret = 1'b0;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic         issue;
    logic         out_valid;
    logic         key_loaded;
    logic         err_nokey;

    aes_128_word_loader #(.CORE_LATENCY(L), .CREDITS(CR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .credit_ret(credit_ret),
        .core_state(core_state), .core_key(core_key), .issue(issue),
        .out_valid(out_valid), .key_loaded(key_loaded), .err_nokey(err_nokey)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge; the stimulus thread acts 1 unit later.
    int           iss_cyc[$];
    logic [127:0] iss_st[$];
    logic [127:0] iss_key[$];
    int           ov_cyc[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (issue) begin
                iss_cyc.push_back(cyc);
                iss_st.push_back(core_state);
                iss_key.push_back(core_key);
            end
            if (out_valid) ov_cyc.push_back(cyc);
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int last_acc = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        bit           inter;
        logic [127:0] exp_state;
        logic [127:0] exp_key;
    } vec_t;
    vec_t vt[4];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        iss_cyc.delete();
        iss_st.delete();
        iss_key.delete();
        ov_cyc.delete();
    endtask

    task automatic send(input logic sel, input logic [31:0] d, input int budget, output bit ok);
        int w;
        w = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_sel = sel;
        in_data = d;
        while (!in_ready && w < budget) begin
            tick();
            w++;
        end
        if (in_ready) begin
            ok = 1'b1;
            last_acc = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic sendw(input logic sel, input logic [31:0] d);
        bit ok;
        send(sel, d, 50, ok);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got not-accepted want accepted word %h", d);
        end
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input bit inter,
                             input bit load);
        if (inter) begin
            for (int i = 0; i < 4; i++) begin
                if (load) sendw(1'b1, key[127-32*i -: 32]);
                sendw(1'b0, pt[127-32*i -: 32]);
            end
        end else begin
            if (load) for (int i = 0; i < 4; i++) sendw(1'b1, key[127-32*i -: 32]);
            for (int i = 0; i < 4; i++) sendw(1'b0, pt[127-32*i -: 32]);
        end
    endtask

    // Expects exactly one issue one cycle after the last word, and out_valid L cycles after that.
    task automatic check_one(input string nm, input logic [127:0] exp_st, input logic [127:0] exp_key);
        for (int i = 0; i < L + 3; i++) tick();
        chk({nm, "_issue_cnt"}, 128'(iss_cyc.size()), 128'd1);
        if (iss_cyc.size() > 0) begin
            chk({nm, "_issue_cyc"}, 128'(iss_cyc[0]), 128'(last_acc + 1));
            chk({nm, "_state"}, iss_st[0], exp_st);
            chk({nm, "_key"}, iss_key[0], exp_key);
        end
        chk({nm, "_ov_cnt"}, 128'(ov_cyc.size()), 128'd1);
        if (ov_cyc.size() > 0) chk({nm, "_ov_cyc"}, 128'(ov_cyc[0]), 128'(last_acc + 1 + L));
        $display("blk %s state=%h key=%h issues=%0d", nm, exp_st, exp_key, iss_cyc.size());
        clear_log();
    endtask

    task automatic pulse_ret();
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [127:0] k2, s2;

        vt[0] = '{128'h0, 128'h0, 1'b0, 128'h0, 128'h0};
        vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 1'b0,
                  128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vt[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 1'b1,
                  128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
        vt[3] = '{128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h11111111_22222222_33333333_44444444, 1'b1,
                  128'h11111111_22222222_33333333_44444444, 128'hdeadbeef_01234567_89abcdef_cafef00d};

        // Reset state
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_issue", 128'(issue), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_key_loaded", 128'(key_loaded), 128'd0);
        chk("rst_err_nokey", 128'(err_nokey), 128'd0);
        chk("rst_core_state", core_state, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_credit", 128'(dut.credit_cnt), 128'(CR));

        // State block with no key: discarded, sticky error, no credit used
        run_block(128'h0, 128'h0, 1'b0, 1'b0);
        for (int i = 0; i < L + 3; i++) tick();
        chk("nokey_issue_cnt", 128'(iss_cyc.size()), 128'd0);
        chk("nokey_ov_cnt", 128'(ov_cyc.size()), 128'd0);
        chk("nokey_err", 128'(err_nokey), 128'd1);
        chk("nokey_credit", 128'(dut.credit_cnt), 128'(CR));
        $display("blk nokey discarded err_nokey=%0b", err_nokey);
        clear_log();

        // Table-driven blocks, each with its credit returned afterwards
        for (int v = 0; v < 4; v++) begin
            run_block(vt[v].key, vt[v].pt, vt[v].inter, 1'b1);
            check_one($sformatf("vec%0d", v), vt[v].exp_state, vt[v].exp_key);
            pulse_ret();
            tick();
            chk($sformatf("vec%0d_credit", v), 128'(dut.credit_cnt), 128'(CR));
        end
        chk("err_sticky", 128'(err_nokey), 128'd1);

        // Credit exhaustion: four blocks, then stall, then one credit unblocks the fifth
        for (int i = 0; i < 4; i++) sendw(1'b1, 32'h0000_0000);
        for (int b = 0; b < 4; b++) run_block(128'h0, 128'(b + 1), 1'b0, 1'b0);
        tick();
        chk("exh_in_ready", 128'(in_ready), 128'd0);
        chk("exh_credit", 128'(dut.credit_cnt), 128'd0);
        send(1'b1, 32'h1234_5678, 4, ok);
        chk("exh_blocked", 128'(ok), 128'd0);
        pulse_ret();
        chk("exh_ready_after_ret", 128'(in_ready), 128'd1);
        run_block(128'h0, 128'd5, 1'b0, 1'b0);
        for (int i = 0; i < L + 3; i++) tick();
        chk("exh_issue_cnt", 128'(iss_cyc.size()), 128'd5);
        chk("exh_ov_cnt", 128'(ov_cyc.size()), 128'd5);
        if (iss_cyc.size() == 5) chk("exh_5th_state", iss_st[4], 128'd5);
        if (iss_cyc.size() == 5 && ov_cyc.size() == 5)
            for (int i = 0; i < 5; i++)
                chk($sformatf("exh_lat%0d", i), 128'(ov_cyc[i] - iss_cyc[i]), 128'(L));
        $display("blk exhaustion issues=%0d out_valids=%0d", iss_cyc.size(), ov_cyc.size());
        clear_log();
        for (int i = 0; i < 4; i++) pulse_ret();
        tick();
        chk("exh_credit_back", 128'(dut.credit_cnt), 128'(CR));

        // Issue and credit return on the same edge leave the count unchanged
        run_block(128'h0, 128'hA, 1'b0, 1'b0);
        check_one("simA", 128'hA, 128'h0);
        for (int i = 0; i < 3; i++) sendw(1'b0, 32'h0000_000B);
        credit_ret = 1'b1;
        sendw(1'b0, 32'h0000_000C);
        credit_ret = 1'b0;
        chk("simul_credit", 128'(dut.credit_cnt), 128'd3);
        check_one("simB", 128'h0000000B_0000000B_0000000B_0000000C, 128'h0);

        // Key committed one cycle before the last state word: the new key is used
        k2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        s2 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        for (int i = 0; i < 3; i++) sendw(1'b1, k2[127-32*i -: 32]);
        for (int i = 0; i < 3; i++) sendw(1'b0, s2[127-32*i -: 32]);
        sendw(1'b1, k2[31:0]);
        sendw(1'b0, s2[31:0]);
        check_one("latekey", s2, k2);
        pulse_ret();
        pulse_ret();
        pulse_ret();
        tick();
        chk("credit_saturate", 128'(dut.credit_cnt), 128'(CR));

        // Reset after two state words: partial block lost, key gone
        sendw(1'b0, 32'hFFFF_FFFF);
        sendw(1'b0, 32'hEEEE_EEEE);
        rst_n = 1'b0;
        tick();
        clear_log();
        rst_n = 1'b1;
        tick();
        chk("rst1_key_loaded", 128'(key_loaded), 128'd0);
        chk("rst1_err_nokey", 128'(err_nokey), 128'd0);
        run_block(128'h1, 128'h77, 1'b0, 1'b1);
        check_one("rst1_fresh", 128'h77, 128'h1);
        pulse_ret();

        // Reset with three blocks in flight: none of them may raise out_valid
        for (int b = 0; b < 3; b++) run_block(128'h0, 128'(b + 8), 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        clear_log();
        rst_n = 1'b1;
        for (int i = 0; i < L + 5; i++) tick();
        chk("rst2_ov_cnt", 128'(ov_cyc.size()), 128'd0);
        chk("rst2_issue_cnt", 128'(iss_cyc.size()), 128'd0);
        chk("rst2_key_loaded", 128'(key_loaded), 128'd0);
        chk("rst2_credit", 128'(dut.credit_cnt), 128'(CR));
        $display("blk reset_in_flight out_valids=%0d", ov_cyc.size());
        run_block(128'h1, 128'h0, 1'b0, 1'b1);
        check_one("rst2_fresh", 128'h0, 128'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
